branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor for the in-order RV32 pipeline: a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. It supplies a combinational next-PC prediction to IF and is trained by the resolved branch outcome from EX, which is the `take_branch` result of branch decision. It compares the prediction carried down the pipe against the resolved outcome and raises a same-cycle mispredict/redirect to the PC-select logic.

## Interface
- `ENTRIES`, 64: BTB depth; power of two, 4–1024.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `if_pc` input 32: fetch PC, word-aligned.
- `pred_taken` output 1: predict taken for `if_pc`.
- `pred_target` output 32: predicted next PC; BTB target if `pred_taken`, else `if_pc+4`.
- `ex_valid` input 1: EX holds a valid, non-flushed instruction.
- `ex_branch` input 1: EX instruction is a conditional branch (the `Branch` control).
- `ex_pc` input 32: PC of the EX instruction.
- `ex_taken` input 1: resolved direction (`take_branch`).
- `ex_target` input 32: resolved branch target (`ex_pc+imm`).
- `ex_pred_taken` input 1: `pred_taken` captured at fetch of this instruction.
- `ex_pred_target` input 32: `pred_target` captured at fetch.
- `mispredict` output 1: flush IF/ID and redirect this cycle.
- `redirect_pc` output 32: correct next PC when `mispredict=1`.

## Operation
- Index = `pc[IDXW+1:2]`, where IDXW = log2(ENTRIES). Tag = `pc[31:IDXW+2]`.
- Entry fields: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`. Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup: hit = `valid && tag match`. `pred_taken = hit && ctr[1]`.
- Training happens when `ex_valid && ex_branch`:
  - Hit, taken: ctr increments, saturating at 11; target is rewritten with `ex_target`.
  - Hit, not taken: ctr decrements, saturating at 00.
  - Miss, taken: the entry is allocated or replaced with valid=1, new tag, `ex_target`, ctr=10.
  - Miss, not taken: no write.
- Non-branch predicted taken (`ex_valid && !ex_branch && ex_pred_taken`) is caused by aliasing. The entry at the `ex_pc` index is invalidated when its tag matches.
- `mispredict` is asserted when `ex_valid` and either of the following holds:
  - Branch: `ex_taken != ex_pred_taken`, or `ex_taken && ex_target != ex_pred_target`.
  - Non-branch: `ex_pred_taken`.
- `redirect_pc` = `ex_target` if `ex_branch && ex_taken`, else `ex_pc+4`. Its value is don't-care when `mispredict=0`.
- `ex_valid=0`: no training and `mispredict=0`, regardless of the other ex_* inputs.
- All PC arithmetic is 32-bit modulo; `0xFFFF_FFFC + 4` wraps to 0.

## Timing
- Lookup is combinational from `if_pc` and registered table state: zero-cycle latency.
- A training write is visible to lookup on the cycle after the update edge.
- Same cycle, same index read and write: lookup returns the pre-update entry; there is no bypass.
- `mispredict`/`redirect_pc` are combinational from the ex_* inputs in the same cycle. The PC mux registers them.
- Reset state: all `valid=0`, all `ctr=01`, all tags and targets 0.
- While `rst=1`: `pred_taken=0`, `pred_target=if_pc+4`, `mispredict=0`.
- Reset asserted mid-operation discards all learned state immediately. An update edge that coincides with reset is ignored.

## Configuration
- `BP_PERF_EN` defined: two 32-bit outputs, `perf_branches` and `perf_mispredicts`, are added.
  - `perf_branches` increments on each training event.
  - `perf_mispredicts` increments on each cycle with `mispredict=1`.
  - Both saturate at `32'hFFFF_FFFF`, reset to 0, and update on the same edge as the table.
- Undefined: the perf ports and counters are absent. Predictor behaviour is identical.

## Structure
- Shared package `bp_pkg`:
  - `ctr_t` (2-bit) with localparams SNT/WNT/WT/ST.
  - `btb_entry_t` struct (valid, tag, target, ctr).
  - A `ctr_next(ctr, taken)` saturating function.
- Sub-module `bp_perf_counters` holds the two saturating counters. It is instantiated only under `BP_PERF_EN`.
- Table is flop-based: an array of `btb_entry_t`, written on a single port and read asynchronously.

## Test plan
All scenarios use ENTRIES=64.
- Reset, then `if_pc=0x100` → `pred_taken=0`, `pred_target=0x104`. Assert `rst` with `ex_valid=1`, `ex_pred_taken=1` → `mispredict=0`.
- EX branch at 0x100, taken, target 0x80, `ex_pred_taken=0` → `mispredict=1`, `redirect_pc=0x80`. Next cycle, `if_pc=0x100` → `pred_taken=1`, `pred_target=0x80` (ctr=10).
- Hysteresis on 0x100:
  - Taken again → ctr=11.
  - Not taken → ctr=10, still predicts taken, and that resolution gives `mispredict=1`, `redirect_pc=0x104`.
  - Not taken again → ctr=01, `pred_taken=0`.
  - Further not-taken updates saturate at 00.
- Aliasing: `if_pc=0x200` (index 0, other tag) after training 0x100 → `pred_taken=0`. EX non-branch at 0x100 with `ex_pred_taken=1` → `mispredict=1`, `redirect_pc=0x104`. The entry is invalidated, so the next lookup of 0x100 misses.
- Same-cycle conflict: update 0x100 taken with `if_pc=0x100` on that cycle → old prediction shown. The new prediction appears the following cycle. Also check wrap: branch at `0xFFFF_FFFC` not taken with `ex_pred_taken=1` → `redirect_pc=0x0`.
- `BP_PERF_EN`: 5 branch updates with 2 mispredicts → `perf_branches=5`, `perf_mispredicts=2`. Preload at `0xFFFF_FFFF` via force and add an update → value stays `0xFFFF_FFFF`.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter helper for the BTB branch predictor
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Tag is kept full-width so the package does not depend on ENTRIES;
    // unused upper bits are always written with zero.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// rtl/bp_perf_counters.sv - saturating branch and mispredict event counters
module bp_perf_counters (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic        mispredict_i,
    output logic [31:0] branches_o,
    output logic [31:0] mispredicts_o
);

    logic [31:0] branches_q, branches_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (branch_i && branches_q != 32'hFFFF_FFFF) begin
            branches_d = branches_q + 32'd1;
        end
        if (mispredict_i && mispredicts_q != 32'hFFFF_FFFF) begin
            mispredicts_d = mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign branches_o    = branches_q;
    assign mispredicts_o = mispredicts_q;

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; BP_PERF_EN adds perf counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int IDXW  = $clog2(ENTRIES);
    localparam int TAGSH = IDXW + 2;

    btb_entry_t        table_q [ENTRIES];
    btb_entry_t        if_entry, ex_entry, entry_d;
    logic [IDXW-1:0]   if_idx, ex_idx;
    logic [31:0]       if_tag, ex_tag;
    logic              if_hit, ex_hit, train, wr_en;

    assign if_idx   = if_pc[IDXW+1:2];
    assign ex_idx   = ex_pc[IDXW+1:2];
    assign if_tag   = if_pc >> TAGSH;
    assign ex_tag   = ex_pc >> TAGSH;
    assign if_entry = table_q[if_idx];
    assign ex_entry = table_q[ex_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

    assign pred_taken  = !rst && if_hit && if_entry.ctr[1];
    assign pred_target = pred_taken ? if_entry.target : if_pc + 32'd4;

    assign train = ex_valid && ex_branch;

    // Single write port: a branch trains its entry, a predicted-taken
    // non-branch clears the aliasing entry it hit.
    always_comb begin
        wr_en   = 1'b0;
        entry_d = ex_entry;
        if (train) begin
            if (ex_hit) begin
                wr_en       = 1'b1;
                entry_d.ctr = ctr_next(ex_entry.ctr, ex_taken);
                if (ex_taken) begin
                    entry_d.target = ex_target;
                end
            end else if (ex_taken) begin
                wr_en   = 1'b1;
                entry_d = '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: WT};
            end
        end else if (ex_valid && ex_pred_taken && ex_hit) begin
            wr_en         = 1'b1;
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (wr_en) begin
            table_q[ex_idx] <= entry_d;
        end
    end

    always_comb begin
        mispredict = 1'b0;
        if (ex_valid && !rst) begin
            if (ex_branch) begin
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            end else begin
                mispredict = ex_pred_taken;
            end
        end
    end

    assign redirect_pc = (ex_branch && ex_taken) ? ex_target : ex_pc + 32'd4;

`ifdef BP_PERF_EN
    bp_perf_counters u_perf (
        .clk_i         (clk),
        .rst_i         (rst),
        .branch_i      (train),
        .mispredict_i  (mispredict),
        .branches_o    (perf_branches),
        .mispredicts_o (perf_mispredicts)
    );
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor (ENTRIES=64)
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       nm;
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor #(.ENTRIES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: one vector is applied per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.nm, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e.pt});
            check({e.nm, ".pred_target"}, pred_target, e.ptg);
            check({e.nm, ".mispredict"},  {31'd0, mispredict}, {31'd0, e.mp});
            if (e.mp) begin
                check({e.nm, ".redirect_pc"}, redirect_pc, e.rd);
            end
        end
    end

    task automatic vec(input string nm, input logic [31:0] ipc,
                       input logic v, input logic b, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tg,
                       input logic ppt, input logic [31:0] ptgt,
                       input logic e_pt, input logic [31:0] e_ptg,
                       input logic e_mp, input logic [31:0] e_rd);
        exp_t e;
        @(posedge clk);
        #1;
        if_pc          = ipc;
        ex_valid       = v;
        ex_branch      = b;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tg;
        ex_pred_taken  = ppt;
        ex_pred_target = ptgt;
        e.nm = nm; e.pt = e_pt; e.ptg = e_ptg; e.mp = e_mp; e.rd = e_rd;
        exp_q.push_back(e);
    endtask

    task automatic lookup(input string nm, input logic [31:0] ipc,
                          input logic e_pt, input logic [31:0] e_ptg);
        vec(nm, ipc, 1'b0, 1'b1, ipc, 1'b1, 32'h44, 1'b1, 32'h0, e_pt, e_ptg, 1'b0, 32'h0);
    endtask

    task automatic set_rst(input logic r);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        rst      = r;
    endtask

    initial begin
        // reset behaviour; the branch seen during reset must not be learned
        vec("rst_nonbr", 32'h100, 1, 0, 32'h100, 0, 32'h0,  1, 32'h80,  0, 32'h104, 0, 32'h0);
        vec("rst_br",    32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 0, 32'h0);
        set_rst(1'b0);
        lookup("post_rst", 32'h100, 0, 32'h104);

        // allocate; same-cycle lookup shows the pre-update entry
        vec("alloc",     32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80);
        lookup("alloc_vis", 32'h100, 1, 32'h80);

        // hysteresis 10 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10
        vec("tk_to_st",  32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80,  1, 32'h80,  0, 32'h0);
        vec("nt_from_st",32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 32'h80,  1, 32'h104);
        vec("nt_from_wt",32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 32'h80,  1, 32'h104);
        vec("nt_from_wn",32'h100, 1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 0, 32'h104, 0, 32'h0);
        vec("nt_sat",    32'h100, 1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 0, 32'h104, 0, 32'h0);
        vec("tk_from_sn",32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80);
        lookup("at_wnt",  32'h100, 0, 32'h104);
        vec("tk_from_wn",32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80);
        lookup("at_wt",   32'h100, 1, 32'h80);

        // taken with a different target rewrites it
        vec("retarget",  32'h100, 1, 1, 32'h100, 1, 32'h300, 1, 32'h80, 1, 32'h80,  1, 32'h300);
        lookup("new_tgt", 32'h100, 1, 32'h300);

        // aliasing at index 0
        lookup("alias_miss", 32'h200, 0, 32'h204);
        vec("nb_othertag",32'h100, 1, 0, 32'h200, 0, 32'h0, 1, 32'h300, 1, 32'h300, 1, 32'h204);
        lookup("kept",    32'h100, 1, 32'h300);
        vec("nb_inval",  32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h300, 1, 32'h300, 1, 32'h104);
        lookup("invalid", 32'h100, 0, 32'h104);

        // ex_valid=0 ignores everything else
        vec("exv0",      32'h100, 0, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 0, 32'h0);
        lookup("exv0_nowr", 32'h100, 0, 32'h104);

        // miss not taken writes nothing; wrap of pc+4
        vec("miss_nt",   32'h140, 1, 1, 32'h140, 0, 32'h10, 0, 32'h144, 0, 32'h144, 0, 32'h0);
        lookup("miss_nt_chk", 32'h140, 0, 32'h144);
        vec("wrap",      32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h40, 1, 32'h40,
            0, 32'h0, 1, 32'h0);
        vec("tk_correct",32'h140, 1, 1, 32'h140, 1, 32'h10, 1, 32'h10,  0, 32'h144, 0, 32'h0);
        lookup("learned", 32'h140, 1, 32'h10);

        // mid-operation reset discards learned state
        set_rst(1'b1);
        lookup("rst_mid", 32'h140, 0, 32'h144);
        set_rst(1'b0);
        lookup("after_rst", 32'h140, 0, 32'h144);

`ifdef BP_PERF_EN
        vec("pf1", 32'h0, 1, 1, 32'h400, 1, 32'h500, 0, 32'h404, 0, 32'h4, 1, 32'h500);
        vec("pf2", 32'h0, 1, 1, 32'h400, 1, 32'h500, 1, 32'h500, 0, 32'h4, 0, 32'h0);
        vec("pf3", 32'h0, 1, 1, 32'h400, 1, 32'h500, 1, 32'h500, 0, 32'h4, 0, 32'h0);
        vec("pf4", 32'h0, 1, 1, 32'h400, 0, 32'h500, 0, 32'h404, 0, 32'h4, 0, 32'h0);
        vec("pf5", 32'h0, 1, 1, 32'h400, 0, 32'h500, 1, 32'h500, 0, 32'h4, 1, 32'h404);
        lookup("pf_idle", 32'h0, 0, 32'h4);
        @(negedge clk);
        #1;
        check("perf_branches",    perf_branches,    32'd5);
        check("perf_mispredicts", perf_mispredicts, 32'd2);
        @(posedge clk);
        #1;
        force dut.u_perf.branches_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.branches_q;
        vec("pf_sat", 32'h0, 1, 1, 32'h400, 0, 32'h500, 0, 32'h404, 0, 32'h4, 0, 32'h0);
        lookup("pf_sat_idle", 32'h0, 0, 32'h4);
        @(negedge clk);
        #1;
        check("perf_sat", perf_branches, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

endmodule
